// File: rtl/seg7_pkg.sv
// Shared types and seven-segment constants for the signed decimal display.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHOW    = 2'd2
  } state_t;

  // a..g in bits 0..6
  localparam logic [7:0] SEG_DIGIT [10] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };

  localparam logic [7:0]  SEG_BLANK = 8'h00;
  localparam int unsigned SEG_DP    = 7;

endpackage

// File: rtl/seg7_encode.sv
// Combinational BCD nibble to a..g pattern; non-decimal codes render blank.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] pattern_c
);

  always_comb begin
    pattern_c = SEG_BLANK[6:0];
    if (bcd <= 4'd9) pattern_c = SEG_DIGIT[bcd][6:0];
  end

endmodule

// File: rtl/signed_dec_display.sv
// Signed binary to multiplexed seven-segment driver: double-dabble conversion,
// then cycles MSD..LSD plus a blank frame, with the minus sign on the decimal point.
module signed_dec_display
  import seg7_pkg::*;
#(
  parameter int unsigned NBITS = 8,
  parameter int unsigned NDIG  = 3,
  parameter int unsigned DWELL = 4
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic [NBITS-1:0] value_in,
  input  logic             load,
  output logic             ready,
  output logic             busy,
  output logic [7:0]       seg
);

  localparam int unsigned BW = 4 * NDIG;
  localparam int unsigned SW = $clog2(NBITS);
  localparam int unsigned DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int unsigned PW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t state, state_nxt;

  logic             sign;
  logic [NBITS-1:0] mag, mag_step, mag_in;
  logic [BW-1:0]    bcd, bcd_adj, bcd_step;
  logic [SW-1:0]    step;
  logic [DW-1:0]    dwell;
  logic [PW-1:0]    ptr, lead_step, lead_cur;
  logic             blank;
  logic [3:0]       cur_digit;
  logic [6:0]       pattern;
  logic [7:0]       seg_nxt;
  logic             last_step;

  // Index of the most-significant non-zero digit; 0 when the value is zero
  function automatic logic [PW-1:0] lead_digit(input logic [BW-1:0] b);
    logic [PW-1:0] l;
    l = '0;
    for (int i = 0; i < int'(NDIG); i++)
      if (b[i*4 +: 4] != 4'd0) l = PW'(i);
    return l;
  endfunction

  // One double-dabble step: add-3 correction, then shift {bcd,mag} left
  always_comb begin
    logic [BW+NBITS-1:0] shifted;
    bcd_adj = '0;
    for (int i = 0; i < int'(NDIG); i++)
      bcd_adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
    shifted  = {bcd_adj, mag} << 1;
    bcd_step = shifted[BW+NBITS-1:NBITS];
    mag_step = shifted[NBITS-1:0];
  end

  assign mag_in    = value_in[NBITS-1] ? NBITS'(0 - value_in) : value_in;
  assign last_step = (step == SW'(NBITS - 1));
  assign lead_step = lead_digit(bcd_step);
  assign lead_cur  = lead_digit(bcd);

  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < int'(NDIG); i++)
      if (ptr == PW'(i)) cur_digit = bcd[i*4 +: 4];
  end

  seg7_encode u_encode (
    .bcd       (cur_digit),
    .pattern_c (pattern)
  );

  always_comb begin
    seg_nxt = SEG_BLANK;
    if (state == SHOW && !blank) begin
      seg_nxt[6:0]   = pattern;
      seg_nxt[SEG_DP] = sign;
    end
  end

  always_ff @(posedge clk_2) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = CONVERT;
      CONVERT: if (last_step) state_nxt = SHOW;
      SHOW:    if (load) state_nxt = CONVERT;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath, frame sequencing and registered outputs
  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      sign  <= 1'b0;
      mag   <= '0;
      bcd   <= '0;
      step  <= '0;
      dwell <= '0;
      ptr   <= '0;
      blank <= 1'b0;
      ready <= 1'b1;
      busy  <= 1'b0;
      seg   <= SEG_BLANK;
    end else begin
      ready <= (state != CONVERT);
      busy  <= (state == CONVERT);
      seg   <= seg_nxt;
      if ((state == IDLE || state == SHOW) && load) begin
        sign  <= value_in[NBITS-1];
        mag   <= mag_in;
        bcd   <= '0;
        step  <= '0;
        dwell <= '0;
        ptr   <= '0;
        blank <= 1'b0;
      end else if (state == CONVERT) begin
        bcd  <= bcd_step;
        mag  <= mag_step;
        step <= step + SW'(1);
        if (last_step) begin
          ptr   <= lead_step;
          dwell <= '0;
          blank <= 1'b0;
        end
      end else if (state == SHOW) begin
        if (dwell == DW'(DWELL - 1)) begin
          dwell <= '0;
          if (blank) begin
            blank <= 1'b0;
            ptr   <= lead_cur;
          end else if (ptr == '0) begin
            blank <= 1'b1;
          end else begin
            ptr <= ptr - PW'(1);
          end
        end else begin
          dwell <= dwell + DW'(1);
        end
      end
    end
  end

endmodule
